// File: rtl/mem_stage_pipelined.sv
// MIPS memory stage with MEM/WB register, sized loads/stores, configurable
// load latency (IDLE/BUSY stall handshake), branch resolution and
// misaligned-access detection.
module mem_stage_pipelined #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic              branch,
  input  logic              branch_ne,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic [31:0]       branch_target,
  input  logic [4:0]        dest_reg,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  output logic              stall,
  output logic              pc_src,
  output logic [31:0]       branch_target_out,
  output logic              misalign,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [4:0]        wb_dest_reg,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                misal_c;
  logic                do_store_c;
  logic                do_load_c;
  logic                stall_c;
  logic [ADDR_W-1:0]   idx_c;
  logic [3:0]          be_c;
  logic [DATA_W-1:0]   wlane_c;
  logic [DATA_W-1:0]   rword_c;
  logic [7:0]          rbyte_c;
  logic [15:0]         rhalf_c;
  logic [DATA_W-1:0]   ext_c;

  logic                wb_valid_q, wb_reg_write_q, wb_mem_to_reg_q, misalign_q;
  logic [4:0]          wb_dest_reg_q;
  logic [DATA_W-1:0]   wb_read_data_q, wb_alu_result_q;

  // Upper address bits are deliberately ignored so addresses wrap.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^alu_result[DATA_W-1:ADDR_W+2];

  // Decode access, alignment, byte enables, load extraction and stall.
  always_comb begin
    idx_c      = alu_result[ADDR_W+1:2];
    misal_c    = ((mem_size == 2'b01) && alu_result[0]) ||
                 (mem_size[1] && (alu_result[1:0] != 2'b00));
    do_store_c = valid_in && !misal_c && mem_write;
    do_load_c  = valid_in && !misal_c && mem_read && !mem_write;

    be_c    = 4'b1111;
    wlane_c = write_data;
    case (mem_size)
      2'b00: begin
        be_c    = 4'b0001 << alu_result[1:0];
        wlane_c = {4{write_data[7:0]}};
      end
      2'b01: begin
        be_c    = alu_result[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{write_data[15:0]}};
      end
      default: ;
    endcase

    rword_c = mem_q[idx_c];
    case (alu_result[1:0])
      2'b00:   rbyte_c = rword_c[7:0];
      2'b01:   rbyte_c = rword_c[15:8];
      2'b10:   rbyte_c = rword_c[23:16];
      default: rbyte_c = rword_c[31:24];
    endcase
    rhalf_c = alu_result[1] ? rword_c[31:16] : rword_c[15:0];
    case (mem_size)
      2'b00:   ext_c = mem_unsigned ? {{(DATA_W-8){1'b0}}, rbyte_c}
                                    : {{(DATA_W-8){rbyte_c[7]}}, rbyte_c};
      2'b01:   ext_c = mem_unsigned ? {{(DATA_W-16){1'b0}}, rhalf_c}
                                    : {{(DATA_W-16){rhalf_c[15]}}, rhalf_c};
      default: ext_c = rword_c;
    endcase

    // BUSY with count 0 is the final cycle: data is captured at its edge.
    stall_c = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (RD_LAT != 0) begin
      if (state_q == IDLE) begin
        stall_c = do_load_c;
        if (do_load_c) begin
          state_d = BUSY;
          cnt_d   = 3'(RD_LAT - 1);
        end
      end else begin
        stall_c = (cnt_q != 3'd0);
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
    end
  end

  // Byte-lane store into data memory; contents are never reset.
  always_ff @(posedge clk) begin
    if (do_store_c) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[idx_c][8*b +: 8] <= wlane_c[8*b +: 8];
      end
    end
  end

  // Latency FSM and MEM/WB register; stalled cycles insert a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_dest_reg_q   <= '0;
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
      misalign_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_c) begin
        wb_valid_q     <= 1'b0;
        wb_reg_write_q <= 1'b0;
        misalign_q     <= 1'b0;
      end else begin
        wb_valid_q      <= valid_in;
        wb_reg_write_q  <= valid_in && reg_write && !misal_c;
        misalign_q      <= valid_in && misal_c;
        wb_mem_to_reg_q <= mem_to_reg;
        wb_dest_reg_q   <= dest_reg;
        wb_alu_result_q <= alu_result;
        wb_read_data_q  <= do_load_c ? ext_c : '0;
      end
    end
  end

  assign stall             = stall_c;
  assign pc_src            = valid_in && branch && (alu_zero ^ branch_ne) && (state_q != BUSY);
  assign branch_target_out = branch_target;
  assign misalign          = misalign_q;
  assign wb_valid          = wb_valid_q;
  assign wb_reg_write      = wb_reg_write_q;
  assign wb_mem_to_reg     = wb_mem_to_reg_q;
  assign wb_dest_reg       = wb_dest_reg_q;
  assign wb_read_data      = wb_read_data_q;
  assign wb_alu_result     = wb_alu_result_q;

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// Directed bench for mem_stage_pipelined: an RD_LAT=2 instance and an
// RD_LAT=0 instance share the same stimulus.
module tb_mem_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic        branch, branch_ne, alu_zero, reg_write, mem_to_reg;
  logic [31:0] alu_result, write_data, branch_target;
  logic [4:0]  dest_reg;

  logic        stall, pc_src, misalign, wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [31:0] branch_target_out, wb_read_data, wb_alu_result;
  logic [4:0]  wb_dest_reg;

  logic        z_stall, z_pc_src, z_misalign, z_wb_valid, z_wb_reg_write, z_wb_mem_to_reg;
  logic [31:0] z_branch_target_out, z_wb_read_data, z_wb_alu_result;
  logic [4:0]  z_wb_dest_reg;

  int n_cmp = 0;
  int n_err = 0;
  int sc;
  logic bub;

  always #5 clk = ~clk;

  mem_stage_pipelined #(.DATA_W(32), .DEPTH(256), .ADDR_W(8), .RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .branch(branch), .branch_ne(branch_ne), .alu_zero(alu_zero),
    .alu_result(alu_result), .write_data(write_data), .branch_target(branch_target),
    .dest_reg(dest_reg), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .stall(stall), .pc_src(pc_src), .branch_target_out(branch_target_out),
    .misalign(misalign), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_dest_reg(wb_dest_reg),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result)
  );

  mem_stage_pipelined #(.DATA_W(32), .DEPTH(256), .ADDR_W(8), .RD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .branch(branch), .branch_ne(branch_ne), .alu_zero(alu_zero),
    .alu_result(alu_result), .write_data(write_data), .branch_target(branch_target),
    .dest_reg(dest_reg), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .stall(z_stall), .pc_src(z_pc_src), .branch_target_out(z_branch_target_out),
    .misalign(z_misalign), .wb_valid(z_wb_valid), .wb_reg_write(z_wb_reg_write),
    .wb_mem_to_reg(z_wb_mem_to_reg), .wb_dest_reg(z_wb_dest_reg),
    .wb_read_data(z_wb_read_data), .wb_alu_result(z_wb_alu_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 0; mem_read = 0; mem_write = 0; mem_size = 2'b10; mem_unsigned = 0;
    branch = 0; branch_ne = 0; alu_zero = 0; alu_result = '0; write_data = '0;
    branch_target = '0; dest_reg = '0; reg_write = 0; mem_to_reg = 0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
    idle();
    valid_in = 1; mem_write = 1; mem_size = sz; alu_result = addr; write_data = data;
    #1;
    check("store_nostall", {31'b0, stall}, 32'd0);
    tick();
    idle();
  endtask

  // Issues a load, holds it while stalled (bounded), returns stall cycles.
  task automatic load(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                      output int cycles, output logic bubble);
    idle();
    valid_in = 1; mem_read = 1; mem_size = sz; mem_unsigned = uns; alu_result = addr;
    reg_write = 1; mem_to_reg = 1; dest_reg = 5'd7;
    #1;
    cycles = 0;
    bubble = 1'b1;
    while (stall === 1'b1 && cycles < 20) begin
      cycles++;
      tick();
      if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) bubble = 1'b0;
    end
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    #1;
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_reg_write", {31'b0, wb_reg_write}, 32'd0);
    check("rst_wb_read_data", wb_read_data, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);

    // Word store then latency-2 load
    store(32'h10, 32'hDEADBEEF, 2'b10);
    check("sw_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("sw_wb_reg_write", {31'b0, wb_reg_write}, 32'd0);
    load(32'h10, 2'b10, 1'b0, sc, bub);
    check("lw_stall_cycles", sc, 32'd2);
    check("lw_bubble", {31'b0, bub}, 32'd1);
    check("lw_data", wb_read_data, 32'hDEADBEEF);
    check("lw_reg_write", {31'b0, wb_reg_write}, 32'd1);
    check("lw_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("lw_dest", {27'b0, wb_dest_reg}, 32'd7);
    check("lw_alu", wb_alu_result, 32'h10);

    // Byte store and sized loads
    store(32'h11, 32'h00000080, 2'b00);
    load(32'h10, 2'b10, 1'b0, sc, bub); check("sb_lw", wb_read_data, 32'hDEAD80EF);
    load(32'h11, 2'b00, 1'b0, sc, bub); check("lb", wb_read_data, 32'hFFFFFF80);
    load(32'h11, 2'b00, 1'b1, sc, bub); check("lbu", wb_read_data, 32'h00000080);
    load(32'h12, 2'b01, 1'b0, sc, bub); check("lh", wb_read_data, 32'hFFFFDEAD);
    load(32'h12, 2'b01, 1'b1, sc, bub); check("lhu", wb_read_data, 32'h0000DEAD);

    // Misaligned half load and word store
    idle();
    valid_in = 1; mem_read = 1; mem_size = 2'b01; alu_result = 32'h13; reg_write = 1;
    #1;
    check("lh_mis_nostall", {31'b0, stall}, 32'd0);
    tick();
    check("lh_mis_pulse", {31'b0, misalign}, 32'd1);
    check("lh_mis_valid", {31'b0, wb_valid}, 32'd1);
    check("lh_mis_regwr", {31'b0, wb_reg_write}, 32'd0);
    idle();
    tick();
    check("mis_one_cycle", {31'b0, misalign}, 32'd0);
    store(32'h12, 32'h00000000, 2'b10);
    check("sw_mis_pulse", {31'b0, misalign}, 32'd1);
    load(32'h10, 2'b10, 1'b0, sc, bub); check("mis_mem_kept", wb_read_data, 32'hDEAD80EF);

    // Branch resolution
    idle();
    valid_in = 1; branch = 1; alu_zero = 1; branch_target = 32'h00400020;
    #1; check("beq_taken", {31'b0, pc_src}, 32'd1);
    check("bt_pass", branch_target_out, 32'h00400020);
    branch_ne = 1; #1; check("bne_zero", {31'b0, pc_src}, 32'd0);
    alu_zero = 0;  #1; check("bne_taken", {31'b0, pc_src}, 32'd1);
    valid_in = 0;  #1; check("br_invalid", {31'b0, pc_src}, 32'd0);
    idle();
    valid_in = 1; mem_read = 1; alu_result = 32'h10; branch = 1; alu_zero = 1; reg_write = 1;
    #1;
    check("br_idle_taken", {31'b0, pc_src}, 32'd1);
    tick();
    check("br_busy_forced", {31'b0, pc_src}, 32'd0);
    check("busy_stall", {31'b0, stall}, 32'd1);
    tick();
    check("busy_last_nostall", {31'b0, stall}, 32'd0);
    check("br_busy_last", {31'b0, pc_src}, 32'd0);
    tick();
    check("br_load_data", wb_read_data, 32'hDEAD80EF);
    idle();

    // Reset in first BUSY cycle
    valid_in = 1; mem_read = 1; alu_result = 32'h10; reg_write = 1;
    #1; check("rb_accept_stall", {31'b0, stall}, 32'd1);
    tick();
    check("rb_busy_stall", {31'b0, stall}, 32'd1);
    rst_n = 0; valid_in = 0; mem_read = 0;
    tick();
    rst_n = 1;
    check("rb_stall", {31'b0, stall}, 32'd0);
    check("rb_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rb_wb_read", wb_read_data, 32'd0);
    valid_in = 1; branch = 1; alu_zero = 1;
    #1; check("rb_fsm_idle", {31'b0, pc_src}, 32'd1);
    idle();
    load(32'h10, 2'b10, 1'b0, sc, bub);
    check("rb_next_stall", sc, 32'd2);
    check("rb_next_data", wb_read_data, 32'hDEAD80EF);

    // Read and write together: store wins
    idle();
    valid_in = 1; mem_read = 1; mem_write = 1; alu_result = 32'h18;
    write_data = 32'h12345678; reg_write = 1;
    #1; check("rw_nostall", {31'b0, stall}, 32'd0);
    tick();
    check("rw_read_zero", wb_read_data, 32'd0);
    check("rw_valid", {31'b0, wb_valid}, 32'd1);
    load(32'h18, 2'b10, 1'b0, sc, bub); check("rw_stored", wb_read_data, 32'h12345678);

    // valid_in low
    idle();
    mem_read = 1; alu_result = 32'h10; reg_write = 1;
    #1; check("inv_nostall", {31'b0, stall}, 32'd0);
    tick();
    check("inv_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("inv_wb_regwr", {31'b0, wb_reg_write}, 32'd0);

    // RD_LAT=0 instance: back-to-back loads
    store(32'h10, 32'h11223344, 2'b10);
    store(32'h14, 32'hCAFEF00D, 2'b10);
    idle();
    valid_in = 1; mem_read = 1; alu_result = 32'h10; reg_write = 1;
    #1; check("l0_stall_a", {31'b0, z_stall}, 32'd0);
    tick();
    alu_result = 32'h14;
    #1;
    check("l0_stall_b", {31'b0, z_stall}, 32'd0);
    check("l0_data_a", z_wb_read_data, 32'h11223344);
    check("l0_valid_a", {31'b0, z_wb_valid}, 32'd1);
    tick();
    check("l0_data_b", z_wb_read_data, 32'hCAFEF00D);
    check("l0_alu_b", z_wb_alu_result, 32'h14);
    check("l0_regwr_b", {31'b0, z_wb_reg_write}, 32'd1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_pipelined.md
Name: mem_stage_pipelined

Overview:
- Parametrised successor to the single-cycle MIPS memory stage. Adds the MEM/WB pipeline register, byte/half/word loads and stores with sign/zero extension, and a configurable-latency data memory with a stall handshake.
- Also adds BEQ/BNE branch resolution and misaligned-access detection.
- Sits between the EX/MEM register and the writeback mux. Drives pc_src back to the fetch stage.

Parameters:
- DATA_W, 32, datapath width; legal values 32 only (byte lanes fixed at 4).
- DEPTH, 256, data memory size in words; power of two.
- ADDR_W, 8, word-index width; equals log2(DEPTH).
- RD_LAT, 2, extra load latency in cycles; legal range 0..7.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  EX/MEM slot holds a real instruction
- mem_read  in  1  load
- mem_write  in  1  store
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned  in  1  zero-extend loads (LBU/LHU)
- branch  in  1  branch instruction
- branch_ne  in  1  1 = BNE, 0 = BEQ
- alu_zero  in  1  ALU zero flag
- alu_result  in  DATA_W  byte address / ALU value
- write_data  in  DATA_W  store data (rt)
- branch_target  in  32  computed branch address
- dest_reg  in  5  destination register
- reg_write  in  1  writeback enable
- mem_to_reg  in  1  writeback select
- stall  out  1  upstream must hold all inputs stable
- pc_src  out  1  take branch
- branch_target_out  out  32  passthrough of branch_target
- misalign  out  1  registered one-cycle fault pulse
- wb_valid  out  1  MEM/WB slot valid
- wb_reg_write  out  1  registered reg_write
- wb_mem_to_reg  out  1  registered mem_to_reg
- wb_dest_reg  out  5  registered dest_reg
- wb_read_data  out  DATA_W  extended load data
- wb_alu_result  out  DATA_W  registered alu_result

Behaviour:
- Reset: sync on clk when rst_n=0.
  - All wb_* = 0, misalign = 0, stall = 0, FSM = IDLE, counter = 0.
  - Memory contents are not reset.
  - Reset during BUSY aborts the load with no writeback; stall is 0 in the cycle after reset is sampled.
- Word index is alu_result[ADDR_W+1:2]; upper address bits are ignored (addresses wrap).
- Alignment fault:
  - half access with addr[0]=1, or word access with addr[1:0]!=0.
  - No memory access occurs.
  - Next edge: misalign=1, wb_valid=1, wb_reg_write=0.
- Stores: written at the edge ending the accept cycle; never stall.
  - Byte lane = addr[1:0] (little-endian); half lanes = addr[1]. Other bytes are preserved.
  - Stores occur only when valid_in=1 and aligned.
- Loads:
  - Byte/half extracted from the addressed lane.
  - Sign-extended unless mem_unsigned=1.
  - Word loads ignore mem_unsigned.
- FSM IDLE/BUSY, latency:
  - RD_LAT=0: no stall; load registered to wb at the next edge.
  - RD_LAT=N>0: an aligned valid load in IDLE asserts stall combinationally in accept cycle t; the edge loads counter=N-1 and moves to BUSY.
  - stall stays 1 through cycle t+N-1.
  - At the edge ending cycle t+N, wb_* capture the instruction, FSM returns to IDLE, and stall drops.
- MEM/WB bubble: wb_valid=0 and wb_reg_write=0 while stall=1.
  - Non-load instructions update wb at the next edge whenever stall=0.
- Branch resolution:
  - pc_src is combinational: valid_in & branch & (alu_zero ^ branch_ne).
  - pc_src is forced 0 while in BUSY.
- mem_read & mem_write both asserted: the store wins; treated as a store with no writeback read data (wb_read_data=0).
- valid_in=0: no memory access; wb_valid=0 and wb_reg_write=0 at the next edge.

Test Plan:
1. Reset, then SW 0xDEADBEEF at addr 0x10, then LW 0x10 with RD_LAT=2 -> stall high exactly 2 cycles; wb_read_data=0xDEADBEEF; wb_reg_write=1.
2. SB 0x80 at addr 0x11 over word 0xDEADBEEF -> LW 0x10 returns 0xDEAD80EF; LB 0x11 returns 0xFFFFFF80; LBU 0x11 returns 0x00000080.
3. LH at 0x13 -> misalign=1 for one cycle; wb_reg_write=0; memory unchanged; stall never asserted.
4. BEQ with alu_zero=1 -> pc_src=1; BNE with alu_zero=1 -> pc_src=0; BNE with alu_zero=0 -> pc_src=1; valid_in=0 -> pc_src=0.
5. rst_n=0 in the first BUSY cycle of an LW -> stall=0 next cycle, wb_valid=0, FSM IDLE; subsequent LW completes normally.
6. RD_LAT=0 build: back-to-back LW 0x10, LW 0x14 -> no stall; wb updates on consecutive edges with correct data.
